// File: rtl/riscv16_ctrl.sv
// ============================================================================
// riscv16_ctrl : multi-cycle control FSM for the 16-bit RiSC core (opt. RISCV16_PERF_CNT_EN)
// Rev 1.0
// ============================================================================
`default_nettype none

module riscv16_ctrl #(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        eq_out,
    input  logic        mem_ready,
    output logic        ADD,
    output logic        NAND,
    output logic        PASS1,
    output logic        EQ,
    output logic        alu_src1_sel,
    output logic        alu_src2_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        addr_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        halted,
    output logic        err
`ifdef RISCV16_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] C_WAIT_LAST = CW'(WAIT_MAX - 1);

    localparam logic [2:0] C_OP_ADD  = 3'b000;
    localparam logic [2:0] C_OP_ADDI = 3'b001;
    localparam logic [2:0] C_OP_NAND = 3'b010;
    localparam logic [2:0] C_OP_LUI  = 3'b011;
    localparam logic [2:0] C_OP_SW   = 3'b100;
    localparam logic [2:0] C_OP_LW   = 3'b101;
    localparam logic [2:0] C_OP_BEQ  = 3'b110;
    localparam logic [2:0] C_OP_JALR = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic [2:0]      w_op;
    logic            w_is_halt;
    logic            w_unused;

    assign w_op      = instr[15:13];
    assign w_is_halt = (w_op == C_OP_JALR) && (instr[6:0] != 7'd0);
    assign w_unused  = ^instr[9:7];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        ADD          = 1'b0;
        NAND         = 1'b0;
        PASS1        = 1'b0;
        EQ           = 1'b0;
        alu_src1_sel = 1'b0;
        alu_src2_sel = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        addr_sel     = 1'b0;
        addr_we      = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'd0;
        rf_we        = 1'b0;
        wb_sel       = 2'd0;
        halted       = 1'b0;
        err          = 1'b0;
        // Outputs are gated by rst so a pending memory request drops immediately.
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        wait_d  = '0;
                        state_d = S_DECODE;
                    end else if (wait_q == C_WAIT_LAST) begin
                        wait_d  = '0;
                        state_d = S_ERROR;
                    end else begin
                        wait_d  = wait_q + CW'(1);
                    end
                end
                S_DECODE: begin
                    state_d = w_is_halt ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    state_d = S_WB;
                    case (w_op)
                        C_OP_ADD:  ADD = 1'b1;
                        C_OP_ADDI: begin
                            ADD          = 1'b1;
                            alu_src2_sel = 1'b1;
                        end
                        C_OP_NAND: NAND = 1'b1;
                        C_OP_LUI: begin
                            PASS1        = 1'b1;
                            alu_src1_sel = 1'b1;
                        end
                        C_OP_SW, C_OP_LW: begin
                            ADD          = 1'b1;
                            alu_src2_sel = 1'b1;
                            addr_we      = 1'b1;
                            state_d      = S_MEM;
                        end
                        C_OP_BEQ: begin
                            EQ      = 1'b1;
                            pc_we   = eq_out;
                            pc_sel  = eq_out ? 2'd1 : 2'd0;
                            state_d = S_FETCH;
                        end
                        default: begin
                            // JALR: link value (PC) written while PC takes alu_out.
                            PASS1   = 1'b1;
                            pc_we   = 1'b1;
                            pc_sel  = 2'd2;
                            rf_we   = 1'b1;
                            wb_sel  = 2'd2;
                            state_d = S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (w_op == C_OP_SW);
                    if (mem_ready) begin
                        wait_d  = '0;
                        state_d = (w_op == C_OP_LW) ? S_WB : S_FETCH;
                    end else if (wait_q == C_WAIT_LAST) begin
                        wait_d  = '0;
                        state_d = S_ERROR;
                    end else begin
                        wait_d  = wait_q + CW'(1);
                    end
                end
                S_WB: begin
                    rf_we   = (instr[12:10] != 3'd0);
                    wb_sel  = (w_op == C_OP_LW) ? 2'd1 : 2'd0;
                    state_d = S_FETCH;
                end
                S_HALT:  halted = 1'b1;
                S_ERROR: err    = 1'b1;
                default: state_d = S_FETCH;
            endcase
        end
    end

`ifdef RISCV16_PERF_CNT_EN
    logic [31:0] cycle_q, instr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            if (state_q != S_HALT && state_q != S_ERROR) begin
                cycle_q <= cycle_q + 32'd1;
            end
            if (state_d == S_FETCH &&
                (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB)) begin
                instr_q <= instr_q + 32'd1;
            end
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
`endif

endmodule

`default_nettype wire

// File: doc/riscv16_ctrl.md
Name: riscv16_ctrl

Overview:
- Multi-cycle control FSM for the 16-bit RiSC core; the producer side of the ALU control interface.
- Decodes the instruction word and drives the one-hot ALU strobes ADD/NAND/PASS1/EQ, consuming eq_out.
- Also sequences PC, IR, register-file, memory-handshake and datapath mux controls for all eight opcodes.

Parameters:
- WAIT_MAX, 15, max cycles FETCH/MEM waits for mem_ready before entering ERROR (1..255).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- instr  in  16  IR contents (valid from DECODE onward)
- eq_out  in  1  ALU equality result
- mem_ready  in  1  memory completes current request this cycle
- ADD, NAND, PASS1, EQ  out  1 each  ALU op strobes, at most one high
- alu_src1_sel  out  1  0=regB, 1=imm10<<6
- alu_src2_sel  out  1  0=regC, 1=sign-extended imm7
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write qualifier for mem_req
- addr_sel  out  1  0=PC, 1=address register
- addr_we  out  1  latch alu_out into address register
- ir_we  out  1  load IR from memory read data
- pc_we  out  1  PC write enable
- pc_sel  out  2  0=PC+1, 1=PC+simm7 (PC already incremented), 2=alu_out
- rf_we  out  1  register-file write to rA
- wb_sel  out  2  0=alu_out, 1=mem read data, 2=PC
- halted  out  1  sticky halt indicator
- err  out  1  sticky memory-timeout indicator

Behaviour:
- One registered state; all outputs combinational from state, instr, eq_out and mem_ready. States: FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR.
- While rst is high: state<=FETCH, wait counter<=0, all outputs 0. First cycle after release: FETCH with mem_req=1.
- Opcode = instr[15:13]: 000 ADD, 001 ADDI, 010 NAND, 011 LUI, 100 SW, 101 LW, 110 BEQ, 111 JALR.
- HALT decode: opcode 111 with instr[6:0]!=0.
- FETCH
  - mem_req=1, addr_sel=0.
  - When mem_ready: ir_we=1, pc_we=1, pc_sel=0, go DECODE.
  - Otherwise stay and increment the wait counter.
- DECODE: no strobes; if HALT, go HALT, else go EXEC.
- EXEC, by opcode:
  - ADD: ADD=1, src2_sel=0 -> WB.
  - ADDI: ADD=1, src2_sel=1 -> WB.
  - NAND: NAND=1, src2_sel=0 -> WB.
  - LUI: PASS1=1, src1_sel=1 -> WB.
  - SW/LW: ADD=1, src2_sel=1, addr_we=1 -> MEM.
  - BEQ: EQ=1; if eq_out, pc_we=1 and pc_sel=1; -> FETCH.
  - JALR: PASS1=1, src1_sel=0, pc_we=1, pc_sel=2, rf_we=1, wb_sel=2 (old PC+1 written before PC update) -> FETCH.
- MEM
  - mem_req=1, addr_sel=1, mem_we=(SW).
  - On mem_ready: LW -> WB, SW -> FETCH.
  - Otherwise stay and count.
- WB: rf_we=1 unless instr[12:10]==0 (r0 never written); wb_sel=1 for LW, else 0; -> FETCH.
- Wait counter
  - Width = clog2(WAIT_MAX+1); cleared on leaving FETCH/MEM.
  - If counter reaches WAIT_MAX with mem_ready still low: go ERROR.
  - mem_ready in the same cycle the counter reaches WAIT_MAX counts as success.
- HALT / ERROR
  - Absorbing until rst; all strobes 0.
  - halted=1 in HALT; err=1 in ERROR.
- Latency with mem_ready tied high:
  - ADD/ADDI/NAND/LUI and SW: 4 cycles.
  - LW: 5 cycles.
  - BEQ/JALR: 3 cycles.
- Invariants
  - ALU strobes are zero outside EXEC.
  - mem_req never deasserts before mem_ready.
  - rst mid-wait drops mem_req the same cycle.

Optional Feature:
- Macro: RISCV16_PERF_CNT_EN.
- When defined: adds outputs cycle_cnt[31:0] and instr_cnt[31:0].
  - cycle_cnt increments every cycle not in HALT/ERROR.
  - instr_cnt increments on each transition into FETCH from EXEC/MEM/WB.
  - Both reset to 0 and wrap at 2^32.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- ADD r1,r2,r3 (16'h0503), mem_ready=1 -> states FETCH,DECODE,EXEC,WB; ADD=1 only in EXEC; rf_we=1 in WB; back to FETCH in cycle 5.
- LW r1,r2,5 (16'hA505), mem_ready delayed 3 cycles in MEM -> addr_we in EXEC; mem_req/addr_sel=1 held 4 cycles with mem_we=0; WB wb_sel=1.
- BEQ (16'hC482), eq_out=1, then eq_out=0 -> EQ=1 both times; pc_we=1, pc_sel=1 only in the first case; 3 cycles each.
- JALR r1,r2 (16'hE500) -> PASS1=1, pc_sel=2, rf_we=1, wb_sel=2 in the same EXEC cycle; 16'hE001 -> halted=1 after DECODE, stays until rst.
- WAIT_MAX=4, mem_ready held low in FETCH -> ERROR entered after the 4th wait cycle, err=1, mem_req=0; rst pulse returns to FETCH with err=0.
- ADDI r0,r0,1 (16'h2001) -> rf_we=0 in WB. Under RISCV16_PERF_CNT_EN: instr_cnt=1 and cycle_cnt=4 after completion.
